branch_predict_unit: RTL and testbench

Parametrised successor to the processor's combinational branch decision logic. It resolves branches at execute with the same opcode decoding and adds a direct-mapped prediction table that the fetch stage reads. The table combines 2-bit saturating counters with a tagged target buffer. The block issues a registered redirect on misprediction and keeps saturating branch and mispredict counters.

---
 rtl/branch_predict_unit.sv | 170 +++++++++++++++++
 tb/tb_branch_predict_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution at execute plus a direct-mapped predictor (2-bit counters
// with tagged targets) read combinationally by fetch; registered redirect on mispredict.
module branch_predict_unit #(
  parameter int WIDTH    = 16,
  parameter int IDX_BITS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] fetch_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_pc,
  input  logic [15:0]      res_command,
  input  logic [3:0]       res_cond,
  input  logic [WIDTH-1:0] res_br,
  input  logic [WIDTH-1:0] res_cr,
  input  logic             res_pred_taken,
  input  logic [WIDTH-1:0] res_pred_target,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] branch_count,
  output logic [WIDTH-1:0] mispredict_count
);

  localparam int unsigned DEPTH = 1 << IDX_BITS;
  localparam int          TAG_W = WIDTH - IDX_BITS;

  logic [1:0]       ctr_q    [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [WIDTH-1:0] target_q [DEPTH];

  // Fetch-side lookup reads the registers directly, so a same-cycle update
  // is only visible from the following cycle.
  logic [IDX_BITS-1:0] fetch_idx;
  logic                fetch_hit;

  assign fetch_idx   = fetch_pc[IDX_BITS-1:0];
  assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_pc[WIDTH-1:IDX_BITS]);
  assign pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
  assign pred_target = pred_taken ? target_q[fetch_idx] : '0;

  logic [4:0] op;
  logic [2:0] sub;
  logic       flag_s;
  logic       flag_z;
  logic       flag_v;
  logic       unused_cond;

  assign op          = res_command[15:11];
  assign sub         = res_command[10:8];
  assign flag_s      = res_cond[3];
  assign flag_z      = res_cond[2];
  assign flag_v      = res_cond[0];
  assign unused_cond = res_cond[1];

  logic is_branch;
  logic taken;
  logic long_offset;

  always_comb begin
    is_branch   = 1'b1;
    taken       = 1'b0;
    long_offset = 1'b0;
    case (op)
      5'b10001: taken = (res_br == res_cr);
      5'b10010: taken = ($signed(res_br) < $signed(res_cr));
      5'b10011: taken = (res_br == WIDTH'(res_command[7:5]));
      5'b10100: begin
        taken       = 1'b1;
        long_offset = 1'b1;
      end
      5'b10101: taken = ($signed(res_br) <= $signed(res_cr));
      5'b10110: taken = (res_br != res_cr);
      5'b10111: begin
        long_offset = 1'b1;
        case (sub)
          3'b000:  taken = flag_z;
          3'b001:  taken = flag_s ^ flag_v;
          3'b010:  taken = flag_z | (flag_s ^ flag_v);
          3'b011:  taken = !flag_z;
          default: is_branch = 1'b0;
        endcase
      end
      default: is_branch = 1'b0;
    endcase
  end

  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] actual_next;
  logic             mispredict;

  assign offset      = long_offset ? WIDTH'($signed(res_command[7:0]))
                                   : WIDTH'($signed(res_command[4:0]));
  assign seq_pc      = res_pc + WIDTH'(1);
  assign br_target   = seq_pc + offset;
  assign actual_next = taken ? br_target : seq_pc;
  assign mispredict  = (taken != res_pred_taken) ||
                       (taken && res_pred_taken && (res_pred_target != br_target));

  logic [IDX_BITS-1:0] res_idx;
  logic [TAG_W-1:0]    res_tag;
  logic                res_hit;
  logic [1:0]          cur_ctr;
  logic [1:0]          upd_ctr;
  logic                upd_valid;
  logic                alloc;

  assign res_idx = res_pc[IDX_BITS-1:0];
  assign res_tag = res_pc[WIDTH-1:IDX_BITS];
  assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
  assign cur_ctr = ctr_q[res_idx];

  // A taken branch that misses (stale tag or invalid entry) claims the slot
  // as weakly taken; a not-taken miss leaves the slot alone.
  always_comb begin
    upd_ctr   = cur_ctr;
    upd_valid = valid_q[res_idx];
    alloc     = 1'b0;
    if (is_branch) begin
      if (taken) begin
        alloc     = 1'b1;
        upd_valid = 1'b1;
        if (!res_hit)
          upd_ctr = 2'b10;
        else if (cur_ctr != 2'b11)
          upd_ctr = cur_ctr + 2'd1;
      end else if (res_hit && (cur_ctr != 2'b00)) begin
        upd_ctr = cur_ctr - 2'd1;
      end
    end else if (res_hit) begin
      upd_valid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctr_q[i[IDX_BITS-1:0]]    <= 2'b01;
        tag_q[i[IDX_BITS-1:0]]    <= '0;
        target_q[i[IDX_BITS-1:0]] <= '0;
      end
      valid_q          <= '0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      redirect_valid <= res_valid && mispredict;
      if (res_valid) begin
        ctr_q[res_idx]   <= upd_ctr;
        valid_q[res_idx] <= upd_valid;
        if (alloc) begin
          tag_q[res_idx]    <= res_tag;
          target_q[res_idx] <= br_target;
        end
        if (mispredict)
          redirect_pc <= actual_next;
        if (is_branch && (branch_count != '1))
          branch_count <= branch_count + WIDTH'(1);
        if (mispredict && (mispredict_count != '1))
          mispredict_count <= mispredict_count + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomised bench for branch_predict_unit: a behavioural model queues expected
// post-edge results, an independent monitor pops and compares them each cycle.
module tb_branch_predict_unit;

  localparam int W  = 8;
  localparam int IB = 4;
  localparam int D  = 16;
  localparam int M  = 255;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] fetch_pc;
  logic         pred_taken;
  logic [W-1:0] pred_target;
  logic         res_valid;
  logic [W-1:0] res_pc;
  logic [15:0]  res_command;
  logic [3:0]   res_cond;
  logic [W-1:0] res_br;
  logic [W-1:0] res_cr;
  logic         res_pred_taken;
  logic [W-1:0] res_pred_target;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic [W-1:0] branch_count;
  logic [W-1:0] mispredict_count;

  always #5 clock = ~clock;

  branch_predict_unit #(.WIDTH(W), .IDX_BITS(IB)) dut (
    .clock(clock), .reset(reset), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_command(res_command),
    .res_cond(res_cond), .res_br(res_br), .res_cr(res_cr),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  typedef struct {
    bit rv;
    int rpc;
    int bc;
    int mc;
  } exp_t;

  exp_t q[$];

  int m_ctr [D];
  bit m_val [D];
  int m_tag [D];
  int m_tgt [D];
  int m_bc, m_mc, m_rpc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_reset();
    for (int i = 0; i < D; i++) begin
      m_ctr[i] = 1;
      m_val[i] = 0;
      m_tag[i] = 0;
      m_tgt[i] = 0;
    end
    m_bc  = 0;
    m_mc  = 0;
    m_rpc = 0;
  endfunction

  function automatic void ref_lookup(input int pc, output bit pt, output int ptgt);
    int idx = pc % D;
    pt   = m_val[idx] && (m_tag[idx] == pc / D) && (m_ctr[idx] >= 2);
    ptgt = pt ? m_tgt[idx] : 0;
  endfunction

  function automatic int to_signed(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic void ref_decide(input int cmd, input int pc, input int br, input int cr,
                                     input int cond, output bit is_br, output bit taken,
                                     output int tgt);
    int op  = (cmd >> 11) & 31;
    int sub = (cmd >> 8) & 7;
    bit s   = (cond >> 3) & 1;
    bit z   = (cond >> 2) & 1;
    bit v   = cond & 1;
    bit lng = 0;
    int off;
    is_br = 1;
    taken = 0;
    case (op)
      17: taken = (br == cr);
      18: taken = (to_signed(br) < to_signed(cr));
      19: taken = (br == ((cmd >> 5) & 7));
      20: begin taken = 1; lng = 1; end
      21: taken = (to_signed(br) <= to_signed(cr));
      22: taken = (br != cr);
      23: begin
        lng = 1;
        case (sub)
          0: taken = z;
          1: taken = s ^ v;
          2: taken = z | (s ^ v);
          3: taken = !z;
          default: is_br = 0;
        endcase
      end
      default: is_br = 0;
    endcase
    if (lng) begin
      off = cmd & 255;
      if (off >= 128) off -= 256;
    end else begin
      off = cmd & 31;
      if (off >= 16) off -= 32;
    end
    tgt = (pc + 1 + off) & M;
  endfunction

  task automatic step(input bit rst, input int fpc, input bit rv, input int pc, input int cmd,
                      input int cond, input int br, input int cr, input bit ppt, input int ptgt);
    bit   ept, is_br, taken, mis;
    int   eptgt, tgt, idx, tag;
    exp_t e;
    @(negedge clock);
    reset           = rst;
    fetch_pc        = fpc[W-1:0];
    res_valid       = rv;
    res_pc          = pc[W-1:0];
    res_command     = cmd[15:0];
    res_cond        = cond[3:0];
    res_br          = br[W-1:0];
    res_cr          = cr[W-1:0];
    res_pred_taken  = ppt;
    res_pred_target = ptgt[W-1:0];
    #1;
    ref_lookup(fpc, ept, eptgt);
    chk("pred_taken", pred_taken, ept);
    chk("pred_target", pred_target, eptgt);
    e.rv = 0;
    if (rst) begin
      ref_reset();
    end else if (rv) begin
      ref_decide(cmd, pc, br, cr, cond, is_br, taken, tgt);
      mis = (taken != ppt) || (taken && ppt && (ptgt != tgt));
      e.rv = mis;
      if (mis) m_rpc = taken ? tgt : ((pc + 1) & M);
      if (is_br && m_bc < M) m_bc++;
      if (mis && m_mc < M) m_mc++;
      idx = pc % D;
      tag = pc / D;
      if (is_br && taken) begin
        m_ctr[idx] = (m_val[idx] && m_tag[idx] == tag) ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3) : 2;
        m_val[idx] = 1;
        m_tag[idx] = tag;
        m_tgt[idx] = tgt;
      end else if (is_br) begin
        if (m_val[idx] && m_tag[idx] == tag && m_ctr[idx] > 0) m_ctr[idx]--;
      end else if (m_val[idx] && m_tag[idx] == tag) begin
        m_val[idx] = 0;
      end
    end
    e.rpc = m_rpc;
    e.bc  = m_bc;
    e.mc  = m_mc;
    q.push_back(e);
  endtask

  task automatic idle(input int fpc);
    step(0, fpc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Resolution carrying whatever the model's table would have predicted for pc.
  task automatic resolve_pred(input int fpc, input int pc, input int cmd, input int cond,
                              input int br, input int cr);
    bit pt;
    int tg;
    ref_lookup(pc, pt, tg);
    step(0, fpc, 1, pc, cmd, cond, br, cr, pt, tg);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("redirect_valid", redirect_valid, e.rv);
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("branch_count", branch_count, e.bc);
        chk("mispredict_count", mispredict_count, e.mc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int ops [8] = '{17, 18, 19, 20, 21, 22, 23, 0};
    int pc, fpc, cmd, br, cr;
    bit pt;
    int tg;
    reset = 1; fetch_pc = '0; res_valid = 0; res_pc = '0; res_command = '0; res_cond = '0;
    res_br = '0; res_cr = '0; res_pred_taken = 0; res_pred_target = '0;
    repeat (2) @(posedge clock);
    ref_reset();

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle('h05);
    step(0, 0, 1, 'h10, 'hA0FE, 0, 0, 0, 0, 0);
    idle('h10);
    step(0, 0, 1, 'h20, 'h8803, 0, 7, 7, 1, 'h24);
    step(0, 0, 1, 'h20, 'h8803, 0, 7, 3, 1, 'h24);
    step(0, 0, 1, 'h40, 'hB902, 'b1000, 0, 0, 0, 0);
    step(0, 0, 1, 'h41, 'hB902, 'b1001, 0, 0, 0, 0);
    step(0, 0, 1, 'h42, 'hBC05, 0, 0, 0, 0, 0);

    // Train one slot with fetch aimed at the same index every cycle.
    repeat (3) resolve_pred('h35, 'h35, 'hA003, 0, 0, 0);
    repeat (2) resolve_pred('h35, 'h35, 'h8803, 0, 1, 2);
    idle('h35);

    for (int n = 0; n < 300; n++) begin
      cmd = (ops[$urandom_range(0, 7)] << 11) | $urandom_range(0, 2047);
      if ($urandom_range(0, 9) == 0) cmd = $urandom_range(0, 65535);
      pc  = ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) pc = $urandom_range(0, M);
      fpc = ($urandom_range(0, 1) == 0) ? pc : (($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      br  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, M);
      cr  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, M);
      ref_lookup(pc, pt, tg);
      if ($urandom_range(0, 3) == 0) pt = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) tg = $urandom_range(0, M);
      step($urandom_range(0, 63) == 0, fpc, $urandom_range(0, 3) != 0, pc, cmd,
           $urandom_range(0, 15), br, cr, pt, tg);
    end

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 260; n++) resolve_pred('h77, 'h77, 'hA001, 0, 0, 0);
    idle('h77);
    step(1, 'h50, 1, 'h50, 'h0000, 0, 0, 0, 1, 0);
    idle('h50);

    for (int n = 0; n < 5 && q.size() > 0; n++) @(posedge clock);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
